ks_adder_arbiter: RTL and testbench
===================================

# ks_adder_arbiter

Round-robin arbiter and sequencer that shares one pipelined N-bit Kogge-Stone adder (`pipe_kogge_stone_Nbit`) among NREQ requesters. It accepts at most one add operation per cycle, drives the adder operand inputs from registers, and tags each operation with its requester ID through a shift pipeline matched to the adder latency. Each result is returned to its requester as a one-cycle response pulse. It sits between the requesting datapath blocks and the single shared adder instance.

## Interface
- `BW`, 32, operand/sum width
- `NREQ`, 4, number of requesters (2..8)
- `LAT`, 2, register stages inside the attached adder (cycles from operand input to `sum`/`cout` valid)
- `CLK`  in  1  clock, rising edge
- `RESETn`  in  1  reset, asynchronous, active-low
- `req`  in  NREQ  per-requester request; operands must be stable while `req[i]` is high
- `req_a`  in  NREQ*BW  operand A, requester i at bits [i*BW +: BW]
- `req_b`  in  NREQ*BW  operand B, same packing
- `req_cin`  in  NREQ  carry-in per requester
- `gnt`  out  NREQ  one-hot accept, combinational, same cycle as `req`
- `add_A`, `add_B`  out  BW  registered operands to adder
- `add_cin`  out  1  registered carry-in to adder
- `add_sum`  in  BW  adder sum
- `add_cout`  in  1  adder carry-out
- `rsp_valid`  out  1  one-cycle result pulse
- `rsp_id`  out  clog2(NREQ)  requester owning the result
- `rsp_sum`  out  BW  registered sum
- `rsp_cout`  out  1  registered carry-out
- `inflight`  out  clog2(LAT+2)  operations issued but not yet responded

## Operation
- Round-robin pointer `ptr` (reset 0). Each cycle, grant the first i scanning `ptr, ptr+1, ... mod NREQ` with `req[i]`=1. At most one `gnt` bit is high per cycle. No `req` means no grant.
- On a grant at an edge: `ptr` <= granted+1 mod NREQ. `add_A/add_B/add_cin` <= that requester's operands. Push {valid=1, id} into the tag pipe.
- With no grant: operand registers hold their values and a valid=0 entry is pushed.
- Tag pipe depth is LAT+1. When the tail entry is valid, `rsp_sum/rsp_cout` <= `add_sum/add_cout`, `rsp_id` <= tag id, and `rsp_valid` pulses for one cycle.
- Responses have no backpressure. Requesters must sink every pulse.
- `inflight` increments on issue and decrements on response. A simultaneous issue and response leaves it unchanged.
- Arithmetic is modulo 2^BW. The carry out of bit BW-1 goes only to `rsp_cout`.
- Asynchronous reset, reachable at any time including with operations in flight:
  - all tags cleared; in-flight operations are discarded with no `rsp_valid` for them;
  - `ptr`=0, `add_A`=`add_B`=0, `add_cin`=0;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `rsp_cout`=0, `inflight`=0.
  - `gnt` is 0 while `RESETn`=0.

## Timing
- Accept at edge E0 (the `req`/`gnt` cycle ends).
- `add_A/B/cin` are valid after E0.
- `add_sum` is valid after E0+LAT.
- `rsp_valid` is high in the cycle after E0+LAT+1. Latency is LAT+1 edges: 3 at the default.
- Throughput is one operation per cycle. Back-to-back grants produce back-to-back `rsp_valid` in issue order.
- Responses never reorder. `rsp_id` sequence equals grant sequence.

## Configuration
- `KS_ARB_LOCK_EN`: adds input `lock` (NREQ bits).
  - If the current grantee holds `lock[i]`=1 and `req[i]`=1, it keeps the grant on following cycles and `ptr` does not advance.
  - The lock releases when `lock[i]` or `req[i]` drops.
  - The lock also releases forcibly after 8 consecutive grants. The counter resets to 0 at reset and on any grant change.
- Undefined: no `lock` port; pure round-robin as above.

## Test plan
- Single request: req[1]=1 with A=0x0000_7530, B=0x0000_C350, cin=0 for one cycle -> gnt[1] in that cycle; 3 cycles later rsp_valid=1, rsp_id=1, rsp_sum=0x0001_3880, rsp_cout=0.
- All four request continuously from reset -> grants 0,1,2,3,0,...; rsp_id follows the same order with one rsp per cycle; inflight saturates at 3.
- Wrap-around: A=0xFFFF_FFFF, B=0x0000_0000, cin=1 -> rsp_sum=0x0000_0000, rsp_cout=1.
- Fairness: req[3] held with req[0] toggling -> req[3] is never skipped twice in a row; ptr wraps from 3 back to 0.
- Reset mid-flight: issue 3 back-to-back operations, assert RESETn=0 between edges before any response -> outputs go to reset values immediately; no rsp_valid after release; inflight=0.
- With `KS_ARB_LOCK_EN`: req[2] and lock[2] held, req[0] high -> gnt[2] for 8 cycles, then gnt[0].

Source files
------------

// File: rtl/ks_adder_arbiter_if.sv
// ---------------------------------------------------------------------------
// ks_adder_arbiter_if
// Bundle of every non-clock signal of ks_adder_arbiter: the requester side
// (req/operands/gnt/rsp_*), the shared adder side (add_* in both directions)
// and the inflight count.
//
// Handshake semantics (one place, applies to the whole bundle):
//   * req[i]/gnt[i] is a valid/ready pair. Requester i raises req[i] with
//     req_a/req_b/req_cin stable and keeps them stable until it sees gnt[i]
//     high at a rising CLK edge; that edge is the transfer. gnt is
//     combinational from req in the same cycle and is at most one-hot.
//   * rsp_valid is valid-only (no ready): a one-cycle pulse that the owner
//     named by rsp_id must consume in that cycle.
//
// Modports: slave  = arbiter view (used by ks_adder_arbiter)
//           master = environment view (requesters plus attached adder)
// Optional: KS_ARB_LOCK_EN adds the per-requester lock vector.
// ---------------------------------------------------------------------------
interface ks_adder_arbiter_if #(
  parameter int BW   = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 2
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IFW = $clog2(LAT + 2);

  logic [NREQ-1:0]    req;
  logic [NREQ*BW-1:0] req_a;
  logic [NREQ*BW-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    gnt;
  logic [BW-1:0]      add_A;
  logic [BW-1:0]      add_B;
  logic               add_cin;
  logic [BW-1:0]      add_sum;
  logic               add_cout;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [BW-1:0]      rsp_sum;
  logic               rsp_cout;
  logic [IFW-1:0]     inflight;

`ifdef KS_ARB_LOCK_EN
  logic [NREQ-1:0]    lock;

  modport slave (
    input  req, req_a, req_b, req_cin, lock, add_sum, add_cout,
    output gnt, add_A, add_B, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout,
           inflight
  );
  modport master (
    output req, req_a, req_b, req_cin, lock, add_sum, add_cout,
    input  gnt, add_A, add_B, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout,
           inflight
  );
`else
  modport slave (
    input  req, req_a, req_b, req_cin, add_sum, add_cout,
    output gnt, add_A, add_B, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout,
           inflight
  );
  modport master (
    output req, req_a, req_b, req_cin, add_sum, add_cout,
    input  gnt, add_A, add_B, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout,
           inflight
  );
`endif
endinterface

// File: rtl/ks_adder_arbiter.sv
// ---------------------------------------------------------------------------
// ks_adder_arbiter
// Round-robin arbiter/sequencer sharing one pipelined Kogge-Stone adder
// (LAT internal register stages) among NREQ requesters. One operation is
// accepted per cycle; operands are registered toward the adder and the
// requester ID rides a LAT+1 deep tag pipe so that the registered result
// comes back as a one-cycle rsp_valid pulse LAT+1 edges after acceptance.
//
// Ports:
//   CLK     in   rising-edge clock
//   RESETn  in   asynchronous active-low reset (clears in-flight work)
//   bus     slave modport of ks_adder_arbiter_if:
//           req/req_a/req_b/req_cin in, gnt out (combinational, one-hot)
//           add_A/add_B/add_cin out (registered), add_sum/add_cout in
//           rsp_valid/rsp_id/rsp_sum/rsp_cout out (registered)
//           inflight out: operations issued but not yet responded
//
// Optional feature macro: KS_ARB_LOCK_EN (bus.lock input; a locked grantee
// keeps the grant for up to 8 consecutive cycles).
// ---------------------------------------------------------------------------
module ks_adder_arbiter #(
  parameter int BW   = 32,
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic              CLK,
  input  logic              RESETn,
  ks_adder_arbiter_if.slave bus
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int IFW = $clog2(LAT + 2);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] gidx;
  logic           issue;
  logic [IDW:0]   scan;
  logic [NREQ-1:0] gnt_c;

  logic [BW-1:0]  add_a_q, add_b_q;
  logic           add_cin_q;

  // Tag pipe: stage 0 is loaded at the accept edge, stage LAT is the tail.
  logic [LAT:0]   tag_vld_q;
  logic [IDW-1:0] tag_id_q [LAT+1];

  logic           rsp_valid_q;
  logic [IDW-1:0] rsp_id_q;
  logic [BW-1:0]  rsp_sum_q;
  logic           rsp_cout_q;
  logic [IFW-1:0] inflight_q, inflight_d;
  logic           rsp_fire;

`ifdef KS_ARB_LOCK_EN
  logic           last_vld_q;
  logic [IDW-1:0] last_id_q;
  logic [3:0]     lock_cnt_q, lock_cnt_d;
  logic           locked;

  // The previous grantee keeps the bus while it still requests and locks,
  // but never for more than 8 consecutive grants.
  assign locked = last_vld_q && bus.lock[last_id_q] && bus.req[last_id_q] &&
                  (lock_cnt_q < 4'd8);
`endif

  always_comb begin
    issue = 1'b0;
    gidx  = '0;
    ptr_d = ptr_q;
    scan  = '0;
    gnt_c = '0;
    // Scan ptr, ptr+1, ... modulo NREQ; the first requester found wins.
    for (int k = 0; k < NREQ; k++) begin
      scan = {1'b0, ptr_q} + (IDW+1)'(k);
      if (scan >= (IDW+1)'(NREQ)) scan = scan - (IDW+1)'(NREQ);
      if (!issue && bus.req[scan[IDW-1:0]]) begin
        issue = 1'b1;
        gidx  = scan[IDW-1:0];
      end
    end
    if (issue) ptr_d = (gidx == IDW'(NREQ - 1)) ? '0 : gidx + IDW'(1);
`ifdef KS_ARB_LOCK_EN
    if (locked) begin
      issue = 1'b1;
      gidx  = last_id_q;
      ptr_d = ptr_q;
    end
    if (!issue)                             lock_cnt_d = '0;
    else if (last_vld_q && gidx == last_id_q)
      lock_cnt_d = (lock_cnt_q == 4'hF) ? lock_cnt_q : lock_cnt_q + 4'd1;
    else                                    lock_cnt_d = 4'd1;
`endif
    gnt_c[gidx] = issue;
  end

  assign rsp_fire = tag_vld_q[LAT];

  always_comb begin
    inflight_d = inflight_q;
    case ({issue, rsp_fire})
      2'b10:   inflight_d = inflight_q + IFW'(1);
      2'b01:   inflight_d = inflight_q - IFW'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      ptr_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      tag_vld_q   <= '0;
      for (int s = 0; s <= LAT; s++) tag_id_q[s] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      inflight_q  <= '0;
`ifdef KS_ARB_LOCK_EN
      last_vld_q  <= 1'b0;
      last_id_q   <= '0;
      lock_cnt_q  <= '0;
`endif
    end else begin
      ptr_q <= ptr_d;
      if (issue) begin
        add_a_q   <= bus.req_a[int'(gidx)*BW +: BW];
        add_b_q   <= bus.req_b[int'(gidx)*BW +: BW];
        add_cin_q <= bus.req_cin[gidx];
      end
      tag_vld_q   <= {tag_vld_q[LAT-1:0], issue};
      tag_id_q[0] <= gidx;
      for (int s = LAT; s > 0; s--) tag_id_q[s] <= tag_id_q[s-1];
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_id_q   <= tag_id_q[LAT];
        rsp_sum_q  <= bus.add_sum;
        rsp_cout_q <= bus.add_cout;
      end
      inflight_q <= inflight_d;
`ifdef KS_ARB_LOCK_EN
      last_vld_q <= issue;
      last_id_q  <= gidx;
      lock_cnt_q <= lock_cnt_d;
`endif
    end
  end

  // Grants are suppressed while reset is asserted.
  assign bus.gnt       = RESETn ? gnt_c : '0;
  assign bus.add_A     = add_a_q;
  assign bus.add_B     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.inflight  = inflight_q;

endmodule

// File: tb/tb_ks_adder_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ks_adder_arbiter
// Directed bench for ks_adder_arbiter. Stimulus pushes the expected
// {rsp_id, rsp_cout, rsp_sum} into exp_q when a grant is expected; an
// independent monitor pops and compares on every rsp_valid pulse. A small
// LAT-stage adder model stands in for the shared Kogge-Stone adder.
// ---------------------------------------------------------------------------
module tb_ks_adder_arbiter;
  localparam int BW   = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 2;
  localparam int W    = 2 + 1 + BW;

  // ---------------- clock / reset ----------------
  logic CLK    = 1'b0;
  logic RESETn = 1'b0;
  always #5 CLK = ~CLK;

  ks_adder_arbiter_if #(.BW(BW), .NREQ(NREQ), .LAT(LAT)) bus ();

  ks_adder_arbiter #(.BW(BW), .NREQ(NREQ), .LAT(LAT)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus.slave)
  );

  // ---------------- attached adder model ----------------
  logic [BW:0] adder_pipe [LAT];
  always @(posedge CLK) begin
    adder_pipe[0] <= {1'b0, bus.add_A} + {1'b0, bus.add_B} + (BW+1)'(bus.add_cin);
    for (int s = 1; s < LAT; s++) adder_pipe[s] <= adder_pipe[s-1];
  end
  assign bus.add_sum  = adder_pipe[LAT-1][BW-1:0];
  assign bus.add_cout = adder_pipe[LAT-1][BW];

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  int checks = 0;
  int errors = 0;
  logic [BW-1:0] op_a [NREQ];
  logic [BW-1:0] op_b [NREQ];
  logic          op_c [NREQ];
  logic [NREQ-1:0] last_gnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d sum=%0h expected no response (t=%0t)",
                 bus.rsp_id, bus.rsp_sum, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rsp", 64'({bus.rsp_id, bus.rsp_cout, bus.rsp_sum}), 64'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_op(input int i, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input logic c);
    op_a[i] = a;
    op_b[i] = b;
    op_c[i] = c;
    bus.req_a[i*BW +: BW] = a;
    bus.req_b[i*BW +: BW] = b;
    bus.req_cin[i]        = c;
  endtask

  function automatic logic [BW:0] res_of(input int i);
    return {1'b0, op_a[i]} + {1'b0, op_b[i]} + (BW+1)'(op_c[i]);
  endfunction

  // Present r for one cycle (called just after a rising edge), check gnt
  // mid-cycle, and queue the expected response when a grant is expected.
  task automatic step(input logic [NREQ-1:0] r, input int exp_g, input logic [BW:0] exp_res);
    logic [NREQ-1:0] exp_oh;
    bus.req = r;
    @(negedge CLK);
    exp_oh = (exp_g < 0) ? '0 : NREQ'(1) << exp_g;
    last_gnt = bus.gnt;
    chk("gnt", 64'(bus.gnt), 64'(exp_oh));
    if (exp_g >= 0) exp_q.push_back({2'(exp_g), exp_res});
    @(posedge CLK);
    #1;
    bus.req = '0;
  endtask

  task automatic drain();
    for (int n = 0; n < 20; n++) begin
      if (exp_q.size() == 0) break;
      @(negedge CLK);
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RESETn = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  // ---------------- stimulus ----------------
  int lat;
  int skip_run;
  int max_skip;

  initial begin
    bus.req     = '1;
    bus.req_a   = '0;
    bus.req_b   = '0;
    bus.req_cin = '0;
`ifdef KS_ARB_LOCK_EN
    bus.lock    = '0;
`endif
    for (int i = 0; i < NREQ; i++) set_op(i, '0, '0, 1'b0);

    // Reset values, with every request raised.
    #3;
    chk("rst_gnt",       64'(bus.gnt),       64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_add_A",     64'(bus.add_A),     64'd0);
    chk("rst_inflight",  64'(bus.inflight),  64'd0);
    chk("rst_rsp_sum",   64'(bus.rsp_sum),   64'd0);
    bus.req = '0;
    @(negedge CLK);
    RESETn = 1'b1;
    @(posedge CLK);
    #1;

    // Single request, 30000 + 50000 = 0x13880.
    set_op(1, 32'h0000_7530, 32'h0000_C350, 1'b0);
    step(4'b0010, 1, {1'b0, 32'h0001_3880});
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLK);
      if (bus.rsp_valid) begin
        lat = n;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd4);
    drain();

    // Wrap-around and carry-out (ptr is 2 here).
    set_op(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    step(4'b0100, 2, {1'b1, 32'h0000_0000});
    set_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    step(4'b0001, 0, {1'b1, 32'h0000_0000});
    step(4'b0000, -1, '0);
    drain();

    // All four requesting continuously from reset.
    do_reset();
    set_op(0, 32'h0000_0001, 32'h0000_0002, 1'b0);
    set_op(1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1);
    set_op(2, 32'h1234_5678, 32'h1111_1111, 1'b0);
    set_op(3, 32'hDEAD_BEEF, 32'h2152_4111, 1'b0);
    for (int k = 0; k < 12; k++) begin
      chk("inflight", 64'(bus.inflight), 64'((k < 3) ? k : 3));
      step(4'b1111, k % 4, res_of(k % 4));
    end
    drain();

    // Fairness: req[3] held, req[0] toggling; ptr wraps 3 -> 0.
    skip_run = 0;
    max_skip = 0;
    for (int k = 0; k < 12; k++) begin
      step((k % 2 == 0) ? 4'b1001 : 4'b1000, (k % 2 == 0) ? 0 : 3,
           (k % 2 == 0) ? res_of(0) : res_of(3));
      if (last_gnt[3]) skip_run = 0;
      else             skip_run++;
      if (skip_run > max_skip) max_skip = skip_run;
    end
    chk("max_skip", 64'(max_skip), 64'd1);
    drain();

    // Reset with three operations in flight.
    for (int k = 0; k < 3; k++) step(4'b1111, k, res_of(k));
    chk("pre_rst_inflight", 64'(bus.inflight), 64'd3);
    bus.req = 4'b1111;
    #2;
    RESETn = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_gnt",       64'(bus.gnt),       64'd0);
    chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("mid_rst_add_A",     64'(bus.add_A),     64'd0);
    chk("mid_rst_add_B",     64'(bus.add_B),     64'd0);
    chk("mid_rst_add_cin",   64'(bus.add_cin),   64'd0);
    chk("mid_rst_inflight",  64'(bus.inflight),  64'd0);
    chk("mid_rst_rsp_id",    64'(bus.rsp_id),    64'd0);
    repeat (3) @(posedge CLK);
    bus.req = '0;
    @(negedge CLK);
    RESETn = 1'b1;
    repeat (6) @(posedge CLK);
    #1;
    chk("post_rst_inflight", 64'(bus.inflight), 64'd0);

    // ptr must be back at 0: requester 0 wins over 3.
    step(4'b1001, 0, res_of(0));
    drain();

`ifdef KS_ARB_LOCK_EN
    // ptr is 1: requester 2 wins, then holds the lock for 8 grants.
    bus.lock = 4'b0100;
    for (int k = 0; k < 9; k++)
      step(4'b0101, (k < 8) ? 2 : 0, (k < 8) ? res_of(2) : res_of(0));
    bus.lock = '0;
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
